// File: rtl/dvemu.sv
// dvemu: sequential signed Q1.23 restoring divider with saturation; DVEMU_ROUND_EN adds a guard bit and rounds half away from zero.
module dvemu #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] quot_o,
  output logic             valid_o
);
`ifdef DVEMU_ROUND_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t            state;
  logic [WIDTH:0]    r;
  logic [WIDTH-1:0]  b;
  logic [QW-1:0]     q;
  logic [CW-1:0]     cnt;
  logic              neg, zero, sat;
  logic [WIDTH-1:0]  a_mag, b_mag, diff, res;
  logic [WIDTH:0]    mag;
  logic              ge, over;
  assign a_mag = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign b_mag = divisor_i[WIDTH-1] ? -divisor_i : divisor_i;
  assign ge    = r >= {1'b0, b};
  assign diff  = ge ? WIDTH'(r - {1'b0, b}) : r[WIDTH-1:0];
`ifdef DVEMU_ROUND_EN
  assign mag   = (WIDTH+1)'(({1'b0, q} + (QW+1)'(1)) >> 1);
`else
  assign mag   = {1'b0, q};
`endif
  // sat covers |a| >= 2|b| (incl. zero divisor), where the 24 quotient bits would overflow
  assign over  = sat | mag[WIDTH] | mag[WIDTH-1];
  assign res   = zero ? '0
               : over ? (neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
               : neg  ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      quot_o  <= '0;
      cnt     <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: if (valid_i) begin
          r       <= {1'b0, a_mag};
          b       <= b_mag;
          q       <= '0;
          cnt     <= '0;
          neg     <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
          zero    <= a_mag == '0;
          sat     <= (a_mag != '0) && ({1'b0, a_mag} >= {b_mag, 1'b0});
          ready_o <= 1'b0;
          state   <= CALC;
        end
        CALC: begin
          r     <= {diff, 1'b0};
          q     <= {q[QW-2:0], ge};
          cnt   <= cnt + 1'b1;
          state <= (cnt == LAST) ? FIX : CALC;
        end
        FIX: begin
          quot_o  <= res;
          valid_o <= 1'b1;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dvemu.sv
// tb_dvemu: directed self-checking bench for the dvemu divider.
module tb_dvemu;
  logic        clk = 1'b0, rst = 1'b1, valid_i = 1'b0;
  logic [23:0] dividend_i = '0, divisor_i = '0;
  logic        ready_o, valid_o;
  logic [23:0] quot_o;
  int          n_chk = 0, n_fail = 0;
`ifdef DVEMU_ROUND_EN
  localparam int          LAT   = 26;
  localparam logic [23:0] THIRD = 24'h2aaaab;
`else
  localparam int          LAT   = 25;
  localparam logic [23:0] THIRD = 24'h2aaaaa;
`endif
  localparam int PER = LAT + 1;

  always #5 clk = ~clk;

  dvemu #(.WIDTH(24)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .dividend_i(dividend_i),
    .divisor_i(divisor_i), .ready_o(ready_o), .quot_o(quot_o), .valid_o(valid_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_div(input string tag, input logic [23:0] a, input logic [23:0] b, input logic [23:0] exp);
    int n;
    bit rdy_bad;
    @(negedge clk);
    check({tag, "_rdy_in"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1; dividend_i = a; divisor_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0; dividend_i = 24'($urandom); divisor_i = 24'($urandom);
    n = 0; rdy_bad = 0;
    while (!valid_o && n < 100) begin
      if (ready_o) rdy_bad = 1;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    check({tag, "_quot"}, 32'(quot_o), 32'(exp));
    check({tag, "_rdy_calc"}, 32'(rdy_bad), 32'd0);
    check({tag, "_rdy_out"}, 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(valid_o), 32'd0);
  endtask

  logic [23:0] va [11], vb [11], ve [11];
  logic [23:0] ha [3], hb [3], he [3];

  initial begin
    int k;
    va[0]  = 24'h100000; vb[0]  = 24'h400000; ve[0]  = 24'h200000;
    va[1]  = 24'hf00000; vb[1]  = 24'h400000; ve[1]  = 24'he00000;
    va[2]  = 24'h400000; vb[2]  = 24'hc00000; ve[2]  = 24'h800000;
    va[3]  = 24'hc00000; vb[3]  = 24'hc00000; ve[3]  = 24'h7fffff;
    va[4]  = 24'h800000; vb[4]  = 24'h800000; ve[4]  = 24'h7fffff;
    va[5]  = 24'h400000; vb[5]  = 24'h200000; ve[5]  = 24'h7fffff;
    va[6]  = 24'h000001; vb[6]  = 24'h000000; ve[6]  = 24'h7fffff;
    va[7]  = 24'h800000; vb[7]  = 24'h000000; ve[7]  = 24'h800000;
    va[8]  = 24'h000000; vb[8]  = 24'h000000; ve[8]  = 24'h000000;
    va[9]  = 24'h000000; vb[9]  = 24'hc00000; ve[9]  = 24'h000000;
    va[10] = 24'h000001; vb[10] = 24'h000003; ve[10] = THIRD;
    ha[0] = 24'h100000; hb[0] = 24'h400000; he[0] = 24'h200000;
    ha[1] = 24'hf00000; hb[1] = 24'h400000; he[1] = 24'he00000;
    ha[2] = 24'h000001; hb[2] = 24'h000003; he[2] = THIRD;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_quot", 32'(quot_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) do_div($sformatf("vec%0d", i), va[i], vb[i], ve[i]);

    // held valid_i with operands changing every cycle; only accept-edge operands count
    k = 0;
    for (int t = 0; t < 3 * PER + 10; t++) begin
      valid_i = (t <= 2 * PER);
      if (t % PER == 0 && t <= 2 * PER) begin
        dividend_i = ha[t / PER]; divisor_i = hb[t / PER];
      end else begin
        dividend_i = 24'($urandom); divisor_i = 24'($urandom);
      end
      @(posedge clk); #1;
      if (valid_o) begin
        if (k < 3) begin
          check($sformatf("hs%0d_edge", k), 32'(t), 32'(LAT + k * PER));
          check($sformatf("hs%0d_quot", k), 32'(quot_o), 32'(he[k]));
        end
        k++;
      end
    end
    valid_i = 1'b0;
    check("hs_pulses", 32'(k), 32'd3);

    // reset 10 cycles into CALC discards the job
    @(negedge clk);
    valid_i = 1'b1; dividend_i = 24'h400000; divisor_i = 24'h600000;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready", 32'(ready_o), 32'd1);
    check("mid_rst_quot", 32'(quot_o), 32'd0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    rst = 1'b0;
    k = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (valid_o) k++;
    end
    check("mid_rst_no_pulse", 32'(k), 32'd0);
    do_div("after_rst", 24'h100000, 24'h400000, 24'h200000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
